my_alu_seq: RTL and testbench
=============================

# my_alu_seq

Parametrised, handshaked successor to the team's combinational Hack ALU. It keeps the six-bit control word (zx, nx, zy, ny, f, no) and adds three things: a WIDTH parameter, a registered output stage with valid/ready flow control, and a multi-cycle shift-add multiply mode. It sits between the CPU operand/decode stage and writeback. The CPU can therefore stall on multiplies and on writeback back-pressure without losing a result.

## Interface
- WIDTH, 16, datapath width in bits; must be ≥2.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- in_valid  in  1  operand/control word offered.
- in_ready  out  1  block can accept an operation this cycle.
- x, y  in  WIDTH  operands.
- zx, nx, zy, ny, f, no  in  1 each  Hack control bits.
- mul  in  1  1 selects multiply mode (f ignored).
- out_valid  out  1  out/zr/ng hold a result.
- out_ready  in  1  consumer accepts the result this cycle.
- out  out  WIDTH  registered result.
- zr  out  1  registered; 1 iff out == 0.
- ng  out  1  registered; equals out[WIDTH-1].

## Operation
- Preprocessing is applied in every mode:
  - xp = zx ? 0 : x, then xp = nx ? ~xp : xp.
  - yp is formed the same way from y, zy and ny.
- ALU mode (mul=0):
  - r = f ? (xp + yp) mod 2^WIDTH : (xp & yp).
  - out = no ? ~r : r.
- Multiply mode (mul=1):
  - r = (xp × yp) mod 2^WIDTH, unsigned; this is also correct low bits for two's complement.
  - out = no ? ~r : r.
- Acceptance occurs when in_valid && in_ready at a clk edge. All inputs are sampled only at acceptance.
- in_ready = (state == IDLE) && (!out_valid || out_ready). It is combinational from out_ready.
- State machine: IDLE, MUL.
  - IDLE, accept with mul=0: load out/zr/ng; set out_valid.
  - IDLE, accept with mul=1: latch xp into a multiplicand register and yp into a multiplier register; clear the accumulator, count = 0, no_q = no; go to MUL.
  - MUL, each cycle:
    - if multiplier[0], acc += multiplicand (mod 2^WIDTH);
    - multiplicand <<= 1; multiplier >>= 1; count++.
  - MUL, on the cycle with count == WIDTH-1: load out = (no_q ? ~acc_next : acc_next) with zr/ng; set out_valid; go to IDLE.
  - MUL never stalls on out_ready. Entry into MUL already required the output register to be free or draining.
- out_valid clears on the edge where out_valid && out_ready, unless a new result is loaded on that same edge. A load wins.
- When out_valid=1 and out_ready=0, out/zr/ng hold stable.
- Reset (asynchronous, any state, including mid-MUL):
  - state = IDLE, out = 0, zr = 0, ng = 0, out_valid = 0;
  - count and the multiply registers are cleared;
  - any in-flight multiply is discarded.

## Timing
- ALU mode latency: accept at edge k, result visible with out_valid=1 after edge k.
- ALU mode throughput: 1 op/cycle while out_ready=1.
- Multiply latency: accept at edge k, result loaded at edge k+WIDTH.
- in_ready is 0 from after edge k until after edge k+WIDTH.
- Earliest next acceptance is edge k+WIDTH+1, provided out_ready=1 then.
- in_ready deasserts asynchronously with out_ready when out_valid=1. No other combinational input-to-output paths exist.
- After rst_n deasserts, in_ready=1 from the first cycle.

## Test plan
- **Hack constants/arithmetic, WIDTH=16, out_ready=1:**
  - zx=1 nx=0 zy=1 ny=0 f=1 no=0 → out=0x0000, zr=1, ng=0.
  - x=0x0005, y=0x0003 with 0 0 0 0 1 0 → out=0x0008.
  - x=3, y=5 with zx0 nx1 zy0 ny0 f1 no1 (x−y) → out=0xFFFE, ng=1, zr=0.
  - All three appear one cycle after acceptance.
- **Throughput and back-pressure:**
  - Four back-to-back ALU ops with out_ready=1 → four results on four consecutive cycles.
  - Hold out_ready=0 for 3 cycles → out stable, in_ready=0.
  - Raise out_ready with in_valid=1 → new op accepted on that same edge; the next result follows one cycle later.
- **Multiply:**
  - mul=1, x=0x0012, y=0x0034, controls 0 → out=0x03A8 with out_valid after edge 16.
  - in_ready=0 for exactly 16 cycles; in_valid pulses during that window are ignored.
- **Multiply wrap/preprocess:**
  - x=0x0100, y=0x0100 → out=0x0000, zr=1.
  - x=3, nx=1, y=2 → out=0xFFF8, ng=1.
  - Same with no=1 → out=0x0007.
- **Reset mid-operation:**
  - Drop rst_n 5 cycles into a multiply → out=0, out_valid=0, zr=0, ng=0 immediately, without waiting for clk.
  - After release, in_ready=1. A new ALU op completes normally with no stale multiply result.
- **Parameter sweep:** WIDTH=8, mul=1, x=0x10, y=0x11 → out=0x10 after edge 8.

Source files
------------

// File: rtl/my_alu_seq.sv
// Hack-style ALU with a registered valid/ready output stage and a multi-cycle
// shift-add multiply mode; the control word is sampled only when an operation is accepted.
module my_alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  mcand_q;
  logic [WIDTH-1:0]  mplier_q;
  logic [WIDTH-1:0]  acc_q;
  logic [CntW-1:0]   count_q;
  logic              no_q;

  logic [WIDTH-1:0]  xp, yp, alu_r, alu_res, acc_next, mul_res;
  logic              accept;

  always_comb begin
    xp = zx ? '0 : x;
    if (nx) xp = ~xp;
    yp = zy ? '0 : y;
    if (ny) yp = ~yp;
    alu_r    = f ? (xp + yp) : (xp & yp);
    alu_res  = no ? ~alu_r : alu_r;
    acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mul_res  = no_q ? ~acc_next : acc_next;
  end

  // Only the output-drain term makes in_ready combinational on out_ready.
  assign in_ready = (state_q == StIdle) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      no_q      <= 1'b0;
      out       <= '0;
      zr        <= 1'b0;
      ng        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // Drain first; a result loaded on the same edge overrides this.
      if (out_valid && out_ready) out_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (!mul) begin
              out       <= alu_res;
              zr        <= ~|alu_res;
              ng        <= alu_res[WIDTH-1];
              out_valid <= 1'b1;
            end else begin
              mcand_q  <= xp;
              mplier_q <= yp;
              acc_q    <= '0;
              count_q  <= '0;
              no_q     <= no;
              state_q  <= StMul;
            end
          end
        end
        StMul: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + CntW'(1);
          if (count_q == LastCnt) begin
            out       <= mul_res;
            zr        <= ~|mul_res;
            ng        <= mul_res[WIDTH-1];
            out_valid <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_my_alu_seq.sv
// Directed bench for my_alu_seq: ALU ops, flow control, multiply, async reset,
// plus a WIDTH=8 instance for the multiply latency sweep.
module tb_my_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic        zx = 0, nx = 0, zy = 0, ny = 0, f = 0, no = 0, mul = 0, zr, ng;
  logic [15:0] x = '0, y = '0, out;

  logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1, zr8, ng8;
  logic [7:0]  x8 = '0, y8 = '0, out8;
  logic        mul8 = 1'b0;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          cyc, lo, seen;

  always #5 clk = ~clk;

  my_alu_seq #(.WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .mul(mul), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .zr(zr), .ng(ng)
  );

  my_alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .x(x8), .y(y8),
    .zx(1'b0), .nx(1'b0), .zy(1'b0), .ny(1'b0), .f(1'b0), .no(1'b0), .mul(mul8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out(out8), .zr(zr8), .ng(ng8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ctl = {zx, nx, zy, ny, f, no}
  task automatic drive(input logic [15:0] xv, input logic [15:0] yv, input logic [5:0] ctl,
                       input logic m);
    {zx, nx, zy, ny, f, no} = ctl;
    x = xv;
    y = yv;
    mul = m;
    in_valid = 1'b1;
  endtask

  task automatic alu_op(input logic [15:0] xv, input logic [15:0] yv, input logic [5:0] ctl);
    @(negedge clk);
    drive(xv, yv, ctl, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Issues a multiply, pulses in_valid while busy, returns latency and in_ready-low count.
  task automatic mul_op(input logic [15:0] xv, input logic [15:0] yv, input logic [5:0] ctl,
                        output int c, output int l);
    @(negedge clk);
    drive(xv, yv, ctl, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    c = 0;
    l = 0;
    while (!out_valid && c < 40) begin
      if (!in_ready) l++;
      @(negedge clk);
      if (c % 2 == 1) drive(16'h1111, 16'h2222, 6'b000010, 1'b0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      c++;
    end
  endtask

  initial begin
    #2;
    check("rst_out", 32'(out), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_zr_ng", 32'({zr, ng}), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_in_ready", 32'(in_ready), 32'h1);

    // Hack constants / arithmetic
    alu_op(16'h1234, 16'h5678, 6'b101010);
    check("const0_out", 32'(out), 32'h0);
    check("const0_flags", 32'({out_valid, zr, ng}), 32'b110);
    alu_op(16'h0005, 16'h0003, 6'b000010);
    check("add_out", 32'(out), 32'h8);
    alu_op(16'h0003, 16'h0005, 6'b010011);
    check("sub_out", 32'(out), 32'hFFFE);
    check("sub_flags", 32'({out_valid, zr, ng}), 32'b101);

    // Back-to-back throughput
    alu_op(16'h0001, 16'h0002, 6'b000010);
    check("b2b_0", 32'(out), 32'h3);
    alu_op(16'h000A, 16'h0014, 6'b000010);
    check("b2b_1", 32'(out), 32'h1E);
    alu_op(16'h0100, 16'h0001, 6'b000010);
    check("b2b_2", 32'(out), 32'h101);
    alu_op(16'hF0F0, 16'hFF00, 6'b000000);
    check("b2b_3_and", 32'(out), 32'hF000);
    check("b2b_valid", 32'(out_valid), 32'h1);
    @(posedge clk);
    #1 check("drain_valid", 32'(out_valid), 32'h0);

    // Back-pressure
    @(negedge clk);
    out_ready = 1'b0;
    drive(16'h0007, 16'h0001, 6'b000010, 1'b0);
    @(posedge clk);
    #1 check("bp_first", 32'(out), 32'h8);
    drive(16'h0002, 16'h0002, 6'b000010, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_out", 32'(out), 32'h8);
      check("bp_hold_vr", 32'({out_valid, in_ready}), 32'b10);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 check("bp_comb_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("bp_next_out", 32'(out), 32'h4);
    check("bp_next_valid", 32'(out_valid), 32'h1);
    @(posedge clk);
    #1 check("bp_drained", 32'(out_valid), 32'h0);

    // Multiply
    mul_op(16'h0012, 16'h0034, 6'b000000, cyc, lo);
    check("mul_lat", 32'(cyc), 32'd16);
    check("mul_busy", 32'(lo), 32'd16);
    check("mul_out", 32'(out), 32'h03A8);
    check("mul_ready_after", 32'(in_ready), 32'h1);
    mul_op(16'h0100, 16'h0100, 6'b000000, cyc, lo);
    check("mul_wrap_out", 32'(out), 32'h0);
    check("mul_wrap_zr", 32'(zr), 32'h1);
    mul_op(16'h0003, 16'h0002, 6'b010000, cyc, lo);
    check("mul_nx_out", 32'(out), 32'hFFF8);
    check("mul_nx_ng", 32'(ng), 32'h1);

    // Asynchronous reset mid-multiply
    @(negedge clk);
    drive(16'h0012, 16'h0034, 6'b000000, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_out", 32'(out), 32'h0);
    check("arst_flags", 32'({out_valid, zr, ng}), 32'b000);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("arst_ready", 32'(in_ready), 32'h1);
    alu_op(16'h0005, 16'h0003, 6'b000010);
    check("arst_alu", 32'(out), 32'h8);
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    check("arst_no_stale", 32'(seen), 32'h0);

    mul_op(16'h0003, 16'h0002, 6'b010001, cyc, lo);
    check("mul_no_out", 32'(out), 32'h0007);
    check("mul_no_lat", 32'(cyc), 32'd16);

    // WIDTH=8 instance
    @(negedge clk);
    x8 = 8'h10;
    y8 = 8'h11;
    mul8 = 1'b1;
    in_valid8 = 1'b1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    cyc = 0;
    while (!out_valid8 && cyc < 40) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("w8_lat", 32'(cyc), 32'd8);
    check("w8_out", 32'(out8), 32'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
